branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the RISC-V core: a direct-mapped, tagged table of 2-bit saturating counters. It is read in the stage where the branch instruction is decoded, producing a taken/not-taken guess that steers fetch. It is written in the execute stage, using the resolved outcome from the branch-resolution logic. It also keeps branch and mispredict counts for the performance CSRs.

## Interface
Parameters:
- LINES, 8: number of table entries; power of two, ≥2.
- PC_WIDTH, 32: address width.

Derived values:
- IDX_W = log2(LINES).
- TAG_W = PC_WIDTH − 2 − IDX_W.

Ports:
- clk  input  1  core clock; one clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_guess  input  PC_WIDTH  PC of instruction being predicted.
- is_br_guess  input  1  instruction at pc_guess is a conditional branch (opcode `OPC_BRANCH`).
- br_pred_taken  output  1  prediction for pc_guess; combinational.
- pc_check  input  PC_WIDTH  PC of branch resolving in execute.
- is_br_check  input  1  instruction at pc_check is a conditional branch; qualifies the update.
- br_taken_check  input  1  resolved outcome (1 = taken).
- br_pred_check  input  1  prediction made earlier for this branch, carried down the pipeline.
- mispredict  output  1  combinational: is_br_check & (br_pred_check ≠ br_taken_check).
- br_count  output  32  branches resolved since reset.
- mispred_count  output  32  mispredictions since reset.

## Operation
- Address split:
  - index = pc[2+IDX_W−1:2]
  - tag = pc[PC_WIDTH−1:2+IDX_W]
  - pc[1:0] ignored.
- Per-entry state: valid (1), tag (TAG_W), ctr (2). Counter encodings:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T
- Lookup (combinational):
  - hit_g = valid[idx_g] & (tag[idx_g] == tag_g).
  - br_pred_taken = is_br_guess & hit_g & ctr[idx_g][1].
  - A miss, or a non-branch, predicts 0.
- Update (at clock edge, when is_br_check = 1):
  - Hit at check index, taken: ctr = min(ctr+1, 3).
  - Hit at check index, not taken: ctr = max(ctr−1, 0).
  - Miss (invalid entry or tag mismatch): allocate. Set valid = 1, tag = tag_c, ctr = 10 if taken, else 01. The previous occupant is overwritten.
  - is_br_check = 0: table unchanged.
- Statistics:
  - br_count += 1 whenever is_br_check.
  - mispred_count += 1 whenever mispredict.
  - Both wrap modulo 2^32; no saturation.
- Reset: all valid = 0, all ctr = 01, both counters = 0. rst overrides any update in the same cycle.

## Timing
- Prediction: zero-cycle combinational path from pc_guess/is_br_guess to br_pred_taken.
- Update latency: visible to a lookup starting the cycle after the update edge.
- Same-cycle collision (guess and check on the same index): lookup sees pre-update contents; no bypass.
- mispredict: combinational from the check inputs, valid in the same cycle. The core uses it to flush and redirect.
- Counter outputs are registered. The value reflects all checks up to and including the previous edge.
- Reset mid-operation:
  - Table and counters clear at the first rst edge.
  - br_pred_taken = 0 from the cycle after that edge, because all entries are invalid.
  - mispredict stays combinational and is not masked by rst.
- Outputs after reset:
  - br_pred_taken = 0.
  - br_count = 0, mispred_count = 0.
  - mispredict = f(inputs).

## Structure
- Shared header branch_pred.vh holds the counter encodings: `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`.
- Branch opcode detection reuses `OPC_BRANCH` from opcode.vh. The core drives is_br_* from its decode logic; no decode inside this block.
- One sub-module: sat_counter_2b. Inputs: current 2-bit state, taken. Output: next state, saturating. The update path instantiates it once.
- Table storage is flip-flop arrays, not SRAM: the lookup is asynchronous and reset clears every valid bit.

## Test plan
All cases use LINES = 8.
- Reset then lookup: rst for 2 cycles; pc_guess = 0x100, is_br_guess = 1 → br_pred_taken = 0, both counts 0.
- Allocate and train:
  - check 0x100 taken → entry weak-T; next-cycle guess of 0x100 → 1.
  - Two not-taken checks → ctr = 00; guess → 0.
  - Three taken checks → ctr saturates at 11; a fourth taken check leaves it at 11.
- Tag aliasing:
  - Train 0x100 to 11.
  - Check 0x120 (same index 0, different tag) not taken → entry replaced with ctr = 01.
  - Guess 0x100 → 0 (miss); guess 0x120 → 0.
- Collision: same cycle, check 0x100 taken (allocation) and guess 0x100 → guess returns 0; next cycle → 1.
- Statistics and mispredict:
  - 5 checks with (pred, taken) = (0,1), (1,1), (1,0), (0,0), (0,1).
  - mispredict pulses on checks 1, 3, 5.
  - br_count = 5, mispred_count = 3.
  - is_br_check = 0 with pred ≠ taken → no pulse, no count.
- Reset mid-training: assert rst in the same cycle as a taken check → that update is dropped; table invalid; counts = 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and opcode constant for the branch predictor
package branch_predictor_pkg;

    // 2-bit saturating counter states; bit 1 is the taken/not-taken guess
    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    // Conditional branch major opcode; decoded by the core, kept here for reference
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/sat_counter_2b.sv
// rtl/sat_counter_2b.sv - next-state logic of a 2-bit saturating counter
module sat_counter_2b
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward the outcome, holding at the strong ends
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped tagged 2-bit counter branch predictor with perf counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int LINES    = 8,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    output logic                br_pred_taken,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check,
    input  logic                br_pred_check,
    output logic                mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

    // Table held in flops so the lookup is asynchronous and reset clears every entry
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [TAG_W-1:0] tag_d [LINES];
    logic [1:0]       ctr_q [LINES];
    logic [1:0]       ctr_d [LINES];
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] idx_g, idx_c;
    logic [TAG_W-1:0] tag_g, tag_c;
    logic             hit_g, hit_c;
    logic [1:0]       ctr_upd;

    // Instruction-alignment bits never participate in indexing
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

    assign idx_g = pc_guess[2+IDX_W-1:2];
    assign tag_g = pc_guess[PC_WIDTH-1:2+IDX_W];
    assign idx_c = pc_check[2+IDX_W-1:2];
    assign tag_c = pc_check[PC_WIDTH-1:2+IDX_W];

    // Lookup reads pre-update contents, so a same-cycle update is not bypassed
    assign hit_g = valid_q[idx_g] && (tag_q[idx_g] == tag_g);
    assign hit_c = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    assign br_pred_taken = is_br_guess && hit_g && ctr_q[idx_g][1];
    assign mispredict    = is_br_check && (br_pred_check != br_taken_check);
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

    sat_counter_2b u_sat_counter (
        .ctr      (ctr_q[idx_c]),
        .taken    (br_taken_check),
        .ctr_next (ctr_upd)
    );

    // Train on a hit, allocate on a miss, and bump the statistics counters
    always_comb begin
        valid_d         = valid_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        for (int i = 0; i < LINES; i++) begin
            tag_d[i] = tag_q[i];
            ctr_d[i] = ctr_q[i];
        end
        if (is_br_check) begin
            br_count_d = br_count_q + 32'd1;
            if (hit_c) begin
                ctr_d[idx_c] = ctr_upd;
            end else begin
                valid_d[idx_c] = 1'b1;
                tag_d[idx_c]   = tag_c;
                ctr_d[idx_c]   = br_taken_check ? BP_WT : BP_WNT;
            end
        end
        if (mispredict) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    // State register; reset wins over any same-cycle update
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= BP_WNT;
            end
        end else begin
            valid_q         <= valid_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= tag_d[i];
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

endmodule
